// File: rtl/if_id_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, the fetch FSM
// state encoding and small field-extraction helpers.
package if_id_pkg;

    localparam logic [3:0]  OP_LW    = 4'h8;
    localparam logic [3:0]  OP_HALT  = 4'hF;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        HALTED   = 2'd2
    } fetch_state_e;

    function automatic logic [3:0] inst_opcode(input logic [15:0] inst);
        return inst[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [3:0] inst_rs1(input logic [15:0] inst);
        return inst[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [3:0] inst_rs2(input logic [15:0] inst);
        return inst[RS2_MSB:RS2_LSB];
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check of the IF/ID instruction against the load in ID/EX.
// Purely combinational, zero latency; never stalls by itself.
module hazard_detect
    import if_id_pkg::*;
(
    input  logic [15:0] inst_ifid,
    input  logic        valid_ifid,
    input  logic        lw_idex,
    input  logic        rf_wen_idex,
    input  logic [3:0]  rd_idex,
    output logic        hz
);

    logic rs_match;
    logic unused_inst_hi;

    // Only the source fields matter; opcode and rd are consumed elsewhere.
    assign unused_inst_hi = ^inst_ifid[15:8];

    always_comb begin
        rs_match = (rd_idex == inst_rs1(inst_ifid)) || (rd_idex == inst_rs2(inst_ifid));
        hz       = valid_ifid && lw_idex && rf_wen_idex && rs_match;
    end

endmodule

// File: rtl/if_id.sv
// Fetch stage + IF/ID register: PC ownership, one-slot redirect flush, load-use stall, HALT.
// Fetch-to-IF/ID latency 1 cycle; a load-use hazard holds PC and IF/ID for one cycle.
module if_id
    import if_id_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP      = NOP_WORD,
    parameter logic [3:0]  HALT_OP  = OP_HALT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        lw_idex,
    input  logic        rf_wen_idex,
    input  logic [3:0]  rd_idex,
    output logic [15:0] inst_curr_IFID,
    output logic [15:0] pc_added_IFID,
    output logic        valid_IFID,
    output logic        idex_bubble,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  inst_q, inst_d;
    logic [15:0]  pc_added_q, pc_added_d;
    logic         valid_q, valid_d;

    logic         hz;
    logic         is_halt;
    logic         do_advance;
    logic         do_flush;
    logic [15:0]  pc_inc;

    hazard_detect u_hazard_detect (
        .inst_ifid   (inst_q),
        .valid_ifid  (valid_q),
        .lw_idex     (lw_idex),
        .rf_wen_idex (rf_wen_idex),
        .rd_idex     (rd_idex),
        .hz          (hz)
    );

    assign pc_inc  = pc_q + 16'd1;
    assign is_halt = valid_q && (inst_opcode(inst_q) == HALT_OP);

    always_comb begin
        state_d     = state_q;
        do_advance  = 1'b0;
        do_flush    = 1'b0;
        idex_bubble = 1'b0;

        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    do_flush = 1'b1;
                end else if (is_halt) begin
                    // HALT wins over a hazard so the stall slot cannot skip past it.
                    state_d = HALTED;
                end else if (hz) begin
                    idex_bubble = 1'b1;
                    state_d     = LU_STALL;
                end else begin
                    do_advance = 1'b1;
                end
            end
            LU_STALL: begin
                // Hazard is masked here: the bubble has already separated the pair.
                if (redirect) begin
                    do_flush = 1'b1;
                end else begin
                    do_advance = 1'b1;
                end
                state_d = RUN;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        pc_added_d = pc_added_q;
        valid_d    = valid_q;

        if (do_flush) begin
            pc_d       = redirect_pc;
            inst_d     = NOP;
            pc_added_d = 16'h0000;
            valid_d    = 1'b0;
        end else if (do_advance) begin
            pc_d       = pc_inc;
            inst_d     = imem_rdata;
            pc_added_d = pc_inc;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            inst_q     <= NOP;
            pc_added_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            pc_added_q <= pc_added_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_addr      = pc_q;
    assign inst_curr_IFID = inst_q;
    assign pc_added_IFID  = pc_added_q;
    assign valid_IFID     = valid_q;
    assign halted         = (state_q == HALTED);

endmodule

// File: doc/if_id.md
# if_id

Fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU. It owns the program counter and drives the instruction-memory address. It latches the fetched instruction and PC+1 into the IF/ID register that feeds decode and the `id_ex` stage. It detects load-use hazards against the ID/EX register, handles branch/jump redirects with a one-slot flush, and halts fetch on a HALT opcode.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `NOP`, default 16'h0000: instruction word inserted on flush or bubble.
- `HALT_OP`, default 4'hF: opcode (inst[15:12]) that stops fetch.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: synchronous, active-low reset.
- `imem_addr` output 16: PC to instruction memory (combinational read).
- `imem_rdata` input 16: instruction at `imem_addr`, valid in the same cycle.
- `redirect` input 1: taken branch/jal/jr resolved in EX.
- `redirect_pc` input 16: target PC when `redirect`=1.
- `lw_idex` input 1: instruction in ID/EX is a load.
- `rf_wen_idex` input 1: instruction in ID/EX writes the register file.
- `rd_idex` input 4: destination register of the ID/EX instruction.
- `inst_curr_IFID` output 16: latched instruction.
- `pc_added_IFID` output 16: latched PC+1 of that instruction.
- `valid_IFID` output 1: IF/ID holds a real instruction.
- `idex_bubble` output 1: forces decode control signals entering `id_ex` to 0.
- `halted` output 1: fetch stopped by HALT.

## Operation
- Instruction fields: opcode [15:12], rd [11:8], rs1 [7:4], rs2 [3:0].
- FSM states are RUN, LU_STALL and HALTED. Reset enters RUN.
- **Load-use hazard** (`hz`): `valid_IFID & lw_idex & rf_wen_idex & (rd_idex==rs1 | rd_idex==rs2)`, evaluated on the IF/ID instruction. `hz` is masked while in LU_STALL.
- **RUN behaviour:**
  - No event: PC←PC+1, IF/ID←{imem_rdata, PC+1}, valid←1.
  - `hz`: PC and IF/ID hold, `idex_bubble`=1, next state LU_STALL.
  - IF/ID opcode==HALT_OP and valid: PC holds, IF/ID holds, next state HALTED.
- **LU_STALL:** lasts exactly one cycle, `idex_bubble`=0, normal advance, then back to RUN.
- **Redirect:** highest priority in every state except HALTED. Effects: PC←redirect_pc, IF/ID←{NOP, 0}, valid←0, state←RUN. `hz` and HALT detection are ignored that cycle.
- **HALTED:** all registers hold, `halted`=1. Only reset exits this state.
- Arithmetic: PC+1 is modulo 2^16, so 16'hFFFF wraps to 16'h0000 with no flag.

## Timing
- Reset values: PC=RESET_PC, inst_curr_IFID=NOP, pc_added_IFID=0, valid_IFID=0, idex_bubble=0, halted=0, state=RUN.
- `imem_addr`=PC, combinational from the register. Fetch-to-IF/ID latency is 1 cycle.
- `idex_bubble` is combinational from `hz` and state. It is asserted in the same cycle the hazard is visible, so the bubble enters ID/EX at the next edge.
- Redirect applied at edge N: the first target instruction appears in IF/ID after edge N+1. Exactly one flushed slot.
- Redirect and `hz` in the same cycle: the redirect wins and no bubble is issued.
- Reset asserted mid-stall or while halted: all reset values apply at the next edge.

## Structure
- A shared CPU package holds the opcode constants (HALT_OP, LW), the field-slice positions, NOP, and the FSM state enum (RUN, LU_STALL, HALTED).
- Sub-module `hazard_detect` is combinational. Its inputs are the IF/ID instruction, valid, lw_idex, rf_wen_idex and rd_idex; its output is `hz`. Everything else is one module.

## Test plan
- **Reset then free-run** from imem words 0x1123, 0x2234: after 2 edges, IF/ID=0x2234, pc_added_IFID=2, valid=1.
- **Load-use hazard:** IF/ID=0x3456 (rs1=5) with lw_idex=1, rf_wen_idex=1, rd_idex=5.
  - `idex_bubble`=1 for exactly one cycle.
  - PC and IF/ID hold for one cycle, then advance.
  - The same case with rd_idex=7 gives no bubble.
- **Redirect to 0x0040:** next cycle IF/ID=NOP and valid=0. One cycle later IF/ID holds imem[0x40] and pc_added_IFID=0x41.
- **Redirect coincident with hazard:** no bubble, and PC=redirect_pc after the edge.
- **HALT:** IF/ID=0xF000 → `halted`=1 and PC frozen for 10 cycles. Reset → PC=RESET_PC, halted=0.
- **Wrap:** PC=0xFFFF advances to 0x0000, and pc_added_IFID=0x0000.
